alu_share_arbiter: RTL

// - Shares the single registered execute ALU between two requesters: req0 (execute stage) and req1 (branch/address helper).
// - Per cycle: picks one requester (round-robin), drives its operands and one-hot op vector to the ALU, and tracks each

---
 rtl/alu_share_arbiter_pkg.sv | 36 +++
 rtl/alu_share_arbiter_if.sv | 24 ++
 rtl/alu_share_arbiter_rr_arb2.sv | 32 +++
 rtl/alu_share_arbiter.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/alu_share_arbiter_pkg.sv
// Shared widths, one-hot op bit positions and requester tagging for the ALU share arbiter.
package alu_share_arbiter_pkg;

  localparam int XLEN = 32;
  localparam int OPW  = 39;
  localparam int IMMW = 12;

  localparam int OP_ADD   = 0;
  localparam int OP_SUB   = 1;
  localparam int OP_AND   = 2;
  localparam int OP_OR    = 3;
  localparam int OP_XOR   = 4;
  localparam int OP_SLL   = 5;
  localparam int OP_SRL   = 6;
  localparam int OP_SRA   = 7;
  localparam int OP_SLT   = 8;
  localparam int OP_SLTU  = 9;
  localparam int OP_LUI   = 10;
  localparam int OP_AUIPC = 11;

  typedef enum logic {
    REQ0 = 1'b0,
    REQ1 = 1'b1
  } req_id_t;

  typedef struct packed {
    logic    valid;
    req_id_t id;
  } tag_t;

  // More than one bit set: clearing the lowest set bit leaves something behind.
  function automatic logic multi_hot(input logic [OPW-1:0] op);
    return |(op & (op - {{(OPW-1){1'b0}}, 1'b1}));
  endfunction

endpackage

// File: rtl/alu_share_arbiter_if.sv
// One requester port of the ALU share arbiter: issue handshake, operands and response pulse.
interface alu_share_arbiter_if;
  import alu_share_arbiter_pkg::*;

  logic            valid;
  logic            ready;
  logic [XLEN-1:0] rs1;
  logic [XLEN-1:0] rs2;
  logic [XLEN-1:0] pc;
  logic [IMMW-1:0] imm;
  logic [OPW-1:0]  instr;
  logic            resp_valid;

  modport master (
    output valid, rs1, rs2, pc, imm, instr,
    input  ready, resp_valid
  );

  modport slave (
    input  valid, rs1, rs2, pc, imm, instr,
    output ready, resp_valid
  );

endinterface

// File: rtl/alu_share_arbiter_rr_arb2.sv
// Two-way round-robin arbiter; grant is combinational, pointer remembers the last winner.
//   state | meaning
//   REQ0  | req0 won last accept, req1 wins next contention
//   REQ1  | req1 won last accept (reset), req0 wins next contention
module rr_arb2
  import alu_share_arbiter_pkg::*;
(
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_valid0,
  input  logic i_valid1,
  input  logic i_accept,
  output logic o_grant0,
  output logic o_grant1
);

  req_id_t r_last;

  always_comb begin
    o_grant0 = i_valid0 & (~i_valid1 | (r_last == REQ1));
    o_grant1 = i_valid1 & (~i_valid0 | (r_last == REQ0));
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_last <= REQ1;
    end else if (i_accept) begin
      r_last <= o_grant1 ? REQ1 : REQ0;
    end
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one registered ALU between req0 and req1: round-robin issue, tag pipe
// tracking ownership through the ALU latency, req0 flush and illegal-op detection.
module alu_share_arbiter
  import alu_share_arbiter_pkg::*;
#(
  parameter  int ALU_LAT = 1,
  localparam int CNTW    = $clog2(ALU_LAT + 1)
) (
  input  logic                i_clk,
  input  logic                i_rst,
  alu_share_arbiter_if.slave  req0_if,
  alu_share_arbiter_if.slave  req1_if,
  input  logic                i_flush0,
  output logic [XLEN-1:0]     o_alu_rs1,
  output logic [XLEN-1:0]     o_alu_rs2,
  output logic [XLEN-1:0]     o_alu_pc,
  output logic [IMMW-1:0]     o_alu_imm,
  output logic [OPW-1:0]      o_alu_instr,
  input  logic [XLEN-1:0]     i_alu_result,
  output logic [XLEN-1:0]     o_resp_data,
  output logic                o_illegal_op,
  output logic                o_illegal_id,
  output logic [CNTW-1:0]     o_inflight
);

  logic            w_v0, w_v1, w_g0, w_g1, w_acc, w_multi;
  req_id_t         w_win_id;
  logic [XLEN-1:0] w_sel_rs1, w_sel_rs2, w_sel_pc;
  logic [IMMW-1:0] w_sel_imm;
  logic [OPW-1:0]  w_sel_instr;
  logic [XLEN-1:0] r_hold_rs1, r_hold_rs2, r_hold_pc;
  logic [IMMW-1:0] r_hold_imm;
  tag_t            r_tag [ALU_LAT];
  tag_t            w_tail;
  logic            w_resp0, w_resp1;
  logic            r_illegal_op, r_illegal_id;
  logic [CNTW-1:0] w_cnt;

  // A flushed req0 is invisible to the arbiter, so req1 can take the slot.
  assign w_v0 = req0_if.valid & ~i_flush0;
  assign w_v1 = req1_if.valid;

  rr_arb2 u_rr_arb2 (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_valid0 (w_v0),
    .i_valid1 (w_v1),
    .i_accept (w_acc),
    .o_grant0 (w_g0),
    .o_grant1 (w_g1)
  );

  assign w_acc         = w_g0 | w_g1;
  assign w_win_id      = w_g1 ? REQ1 : REQ0;
  assign req0_if.ready = w_g0;
  assign req1_if.ready = w_g1;

  always_comb begin
    w_sel_rs1   = req0_if.rs1;
    w_sel_rs2   = req0_if.rs2;
    w_sel_pc    = req0_if.pc;
    w_sel_imm   = req0_if.imm;
    w_sel_instr = req0_if.instr;
    if (w_g1) begin
      w_sel_rs1   = req1_if.rs1;
      w_sel_rs2   = req1_if.rs2;
      w_sel_pc    = req1_if.pc;
      w_sel_imm   = req1_if.imm;
      w_sel_instr = req1_if.instr;
    end
  end

  assign w_multi = w_acc & multi_hot(w_sel_instr);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_hold_rs1 <= '0;
      r_hold_rs2 <= '0;
      r_hold_pc  <= '0;
      r_hold_imm <= '0;
    end else if (w_acc) begin
      r_hold_rs1 <= w_sel_rs1;
      r_hold_rs2 <= w_sel_rs2;
      r_hold_pc  <= w_sel_pc;
      r_hold_imm <= w_sel_imm;
    end
  end

  assign o_alu_rs1   = w_acc ? w_sel_rs1 : r_hold_rs1;
  assign o_alu_rs2   = w_acc ? w_sel_rs2 : r_hold_rs2;
  assign o_alu_pc    = w_acc ? w_sel_pc  : r_hold_pc;
  assign o_alu_imm   = w_acc ? w_sel_imm : r_hold_imm;
  assign o_alu_instr = (w_acc & ~w_multi) ? w_sel_instr : '0;

  // Entries shifting past a flush lose their req0 ownership; req1 entries ride through.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < ALU_LAT; i++) begin
        r_tag[i] <= '{valid: 1'b0, id: REQ0};
      end
    end else begin
      r_tag[0].valid <= w_acc & ~w_multi;
      r_tag[0].id    <= w_win_id;
      for (int i = 1; i < ALU_LAT; i++) begin
        r_tag[i].valid <= r_tag[i-1].valid & ~(i_flush0 & (r_tag[i-1].id == REQ0));
        r_tag[i].id    <= r_tag[i-1].id;
      end
    end
  end

  assign w_tail  = r_tag[ALU_LAT-1];
  assign w_resp0 = w_tail.valid & (w_tail.id == REQ0) & ~i_flush0;
  assign w_resp1 = w_tail.valid & (w_tail.id == REQ1);

  assign req0_if.resp_valid = w_resp0;
  assign req1_if.resp_valid = w_resp1;
  assign o_resp_data        = (w_resp0 | w_resp1) ? i_alu_result : '0;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_illegal_op <= 1'b0;
      r_illegal_id <= 1'b0;
    end else begin
      r_illegal_op <= w_multi;
      r_illegal_id <= w_multi & w_g1;
    end
  end

  assign o_illegal_op = r_illegal_op;
  assign o_illegal_id = r_illegal_id;

  always_comb begin
    w_cnt = '0;
    for (int i = 0; i < ALU_LAT; i++) begin
      w_cnt = w_cnt + CNTW'(r_tag[i].valid);
    end
  end

  assign o_inflight = w_cnt;

endmodule
